// File: rtl/itch_decoder_pkg.sv
// Shared types and ITCH 5.0 message-type constants
// for the fixed-length message decoders.
package itch_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        SKIP,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_UNDERRUN,
        ERR_OVERRUN,
        ERR_RESTART
    } err_t;

    localparam int CNT_BITS = 7;

    localparam logic [7:0] ITCH_SYS_EVENT = 8'h53;
    localparam logic [7:0] ITCH_ADD_ORDER = 8'h41;
    localparam logic [7:0] ITCH_ADD_MPID  = 8'h46;
    localparam logic [7:0] ITCH_DELETE    = 8'h44;
    localparam logic [7:0] ITCH_EXECUTED  = 8'h45;
    localparam logic [7:0] ITCH_EXEC_PX   = 8'h43;
    localparam logic [7:0] ITCH_CANCEL    = 8'h58;
    localparam logic [7:0] ITCH_REPLACE   = 8'h55;
    localparam logic [7:0] ITCH_TRADE     = 8'h50;

endpackage

// File: rtl/itch_lane_packer.sv
// Maps the valid lanes of one beat onto payload byte slots,
// given the stream index of lane 0.
module itch_lane_packer
    import itch_decoder_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int MSG_LENGTH = 9
) (
    input  logic [LANES*8-1:0]          data_in,
    input  logic [CNT_BITS-1:0]         lanes_in,
    input  logic [CNT_BITS-1:0]         byte_cnt,
    output logic [MSG_LENGTH-2:0]       wr_en,
    output logic [(MSG_LENGTH-1)*8-1:0] wr_data
);

    localparam int PB = MSG_LENGTH - 1;

    // Payload slot j holds stream byte PB-j (byte 1 in the MSBs).
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int j = 0; j < PB; j++) begin
            for (int l = 0; l < LANES; l++) begin
                if ((CNT_BITS'(l) < lanes_in) &&
                    (byte_cnt + CNT_BITS'(l) ==
                     CNT_BITS'(PB - j))) begin
                    wr_en[j]        = 1'b1;
                    wr_data[j*8+:8] = data_in[l*8+:8];
                end
            end
        end
    end

endmodule

// File: rtl/itch_fixed_msg_decoder.sv
// Multi-lane ITCH fixed-length message decoder with framing
// error reporting and saturating statistics.
module itch_fixed_msg_decoder
    import itch_decoder_pkg::*;
#(
    parameter logic [7:0] MSG_TYPE   = 8'h44,
    parameter int         MSG_LENGTH = 9,
    parameter int         LANES      = 1,
    parameter int         CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES*8-1:0]           data_in,
    input  logic                         valid_in,
    input  logic                         sof_in,
    input  logic                         eof_in,
    input  logic [$clog2(LANES+1)-1:0]   lanes_in,
    output logic                         msg_valid,
    output logic                         msg_invalid,
    output logic [1:0]                   err_code,
    output logic [(MSG_LENGTH-1)*8-1:0]  msg_payload,
    output logic [CNT_W-1:0]             ok_count,
    output logic [CNT_W-1:0]             err_count
);

    localparam int PB = MSG_LENGTH - 1;
    localparam int LW = $clog2(LANES + 1);
    localparam logic [CNT_BITS-1:0] LEN =
        CNT_BITS'(MSG_LENGTH);

    state_t state, state_nx, eff;
    err_t   err_q, code_d;

    logic [CNT_BITS-1:0] byte_cnt, byte_cnt_nx;
    logic [CNT_BITS-1:0] base, total, lanes_w;
    logic                start, match, acc, restart;
    logic                ok_d, bad_d;
    logic [PB*8-1:0]     shadow, shadow_nx, wr_data;
    logic [PB-1:0]       wr_en;

    assign start   = valid_in & sof_in;
    assign match   = (data_in[7:0] == MSG_TYPE);
    assign restart = start & (state == ACCEPT);
    assign lanes_w = {{(CNT_BITS-LW){1'b0}}, lanes_in};
    assign base    = start ? '0 : byte_cnt;
    assign total   = base + lanes_w;

    // A sof beat is judged as the first beat of a new message,
    // whatever state it arrives in.
    assign eff = start ? (match ? ACCEPT : SKIP) : state;
    assign acc = valid_in & (eff == ACCEPT);

    itch_lane_packer #(
        .LANES      (LANES),
        .MSG_LENGTH (MSG_LENGTH)
    ) u_packer (
        .data_in  (data_in),
        .lanes_in (lanes_w),
        .byte_cnt (base),
        .wr_en    (wr_en),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        if (valid_in) begin
            unique case (eff)
                IDLE:   state_nx = IDLE;
                ACCEPT: begin
                    if (eof_in)
                        state_nx = IDLE;
                    else if (total > LEN)
                        state_nx = DRAIN;
                    else
                        state_nx = ACCEPT;
                end
                SKIP, DRAIN: state_nx = eof_in ? IDLE : eff;
                default: state_nx = IDLE;
            endcase
            byte_cnt_nx = (state_nx == ACCEPT) ? total : '0;
        end
    end

    always_comb begin
        ok_d   = 1'b0;
        bad_d  = 1'b0;
        code_d = ERR_NONE;
        if (restart) begin
            bad_d  = 1'b1;
            code_d = ERR_RESTART;
        end else if (acc) begin
            unique case (1'b1)
                eof_in && (total == LEN): ok_d = 1'b1;
                eof_in && (total < LEN): begin
                    bad_d  = 1'b1;
                    code_d = ERR_UNDERRUN;
                end
                total > LEN: begin
                    bad_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shadow_nx = shadow;
        for (int j = 0; j < PB; j++) begin
            if (acc && wr_en[j])
                shadow_nx[j*8+:8] = wr_data[j*8+:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            msg_valid   <= 1'b0;
            msg_invalid <= 1'b0;
            err_q       <= ERR_NONE;
            msg_payload <= '0;
            ok_count    <= '0;
            err_count   <= '0;
        end else begin
            shadow      <= shadow_nx;
            msg_valid   <= ok_d;
            msg_invalid <= bad_d;
            if (bad_d)
                err_q <= code_d;
            if (ok_d)
                msg_payload <= shadow_nx;
            if (ok_d && (ok_count != '1))
                ok_count <= ok_count + 1'b1;
            if (bad_d && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    assign err_code = err_q;

endmodule
